ysyx_rf_sb: RTL and testbench
=============================

Name: ysyx_rf_sb

Overview:
- Register file plus pending-write scoreboard for the in-order pipeline.
- Serves the decode stage's operand reads (rs1/rs2 -> rdata1/rdata2) and publishes the 16-bit busy table that decode uses for hazard stalls.
- Decode issue events set an entry busy; EXU/WB writebacks write data and clear it.
- Per-register pending counters keep back-to-back writes to the same rd (WAW in flight) from clearing busy too early.

Parameters:
- BIT_W, 32, data width.
- NR_REG, 16, architectural registers (RV32E); index width is 4.
- CNT_W, 2, width of each pending-write counter; at most 2^CNT_W-1 writes in flight per register.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- rs1  in  4  read index 1 from decode.
- rs2  in  4  read index 2 from decode.
- rdata1  out  BIT_W  read data for rs1 (combinational).
- rdata2  out  BIT_W  read data for rs2 (combinational).
- issue_valid  in  1  decode hands an instruction to EXU this cycle (decode valid & next ready).
- issue_wen  in  1  the issued instruction writes rd.
- issue_rd  in  4  destination of the issued instruction.
- issue_ready  out  1  0 when issue_rd's counter is saturated; decode must hold.
- wb_valid  in  1  writeback this cycle.
- wb_wen  in  1  writeback writes the register file.
- wb_rd  in  4  writeback destination.
- wb_data  in  BIT_W  writeback value.
- flush  in  1  speculation squash; all in-flight writes are cancelled.
- rf_table  out  NR_REG  bit i = register i has pending writes.

Behaviour:
- Reset (async, rst=1): all registers = 0; all counters = 0; rf_table = 0; issue_ready = 1. Holding rst mid-operation discards everything immediately.
- x0 rule:
  - Reads of index 0 return 0.
  - Writes and issues to index 0 are ignored.
  - rf_table[0] is always 0.
- Read path: combinational with a writeback bypass. If wb_valid & wb_wen & wb_rd==rs1 & rs1!=0, then rdata1 = wb_data; otherwise rdata1 = reg[rs1]. rdata2 follows the same rule.
- Write: on a clk edge with wb_valid & wb_wen & wb_rd!=0, reg[wb_rd] <= wb_data. Latency is one cycle to the array, zero cycles to readers via the bypass.
- Counters: cnt[i] is CNT_W bits; rf_table[i] = (cnt[i] != 0) comes straight from the registered counter, with no writeback lookahead.
  - inc_i = issue_valid & issue_wen & issue_ready & issue_rd==i & i!=0.
  - dec_i = wb_valid & wb_wen & wb_rd==i & i!=0 & cnt[i]!=0.
  - inc_i & dec_i in the same cycle: cnt unchanged.
  - inc_i only: cnt+1.
  - dec_i only: cnt-1.
  - A writeback to a register with cnt==0 (e.g. after a flush) writes data and leaves cnt at 0, with no underflow.
- issue_ready = !(issue_wen & issue_rd!=0 & cnt[issue_rd]==all-ones & !dec_issue_rd). A same-cycle writeback to that rd frees a slot.
- Flush (a register, not a state machine):
  - On an edge with flush=1, all counters <= 0.
  - Same-cycle issue is ignored.
  - Same-cycle writeback still updates the data array.
  - rf_table reads 0 from the next cycle.
- No other stateful logic. Every output is a function of counters/array and the current inputs.

Decomposition:
- Shared package ysyx_pkg: the register index width constant (4), the NR_REG default, and the x0 index constant.
- One sub-module, ysyx_sb_cnt: a single saturating up/down counter with clear, taking inc/dec/clr and giving busy/full. It is instanced NR_REG-1 times; index 0 is tied off.

Test Plan:
- Reset check: assert rst asynchronously mid-cycle after writing x5=0x1234 -> rdata1 (rs1=5) = 0 immediately; rf_table = 0x0000; issue_ready = 1.
- Issue/writeback: issue rd=3 -> next cycle rf_table = 0x0008. Then wb rd=3, data 0xDEADBEEF -> bypass gives rdata1 = 0xDEADBEEF in the same cycle; rf_table = 0x0000 on the next cycle.
- WAW: issue rd=7 twice on consecutive cycles, then one wb -> rf_table[7] stays 1; second wb -> 0.
- Saturation: 3 issues to rd=2 with CNT_W=2 -> issue_ready = 0 for a 4th. The same cycle with wb rd=2 -> issue_ready = 1 and cnt stays 3.
- x0 and simultaneous events:
  - Issue rd=0 and wb rd=0 with data 0x55 -> rf_table = 0 and rdata1 (rs1=0) = 0.
  - Same-cycle issue rd=4 and wb rd=4 with cnt=1 -> cnt remains 1.
- Flush: rd=1 and rd=9 pending, assert flush together with wb rd=9 data 0xA5 -> rf_table = 0 next cycle; reg9 = 0xA5; a later wb rd=1 leaves cnt at 0.

Source files
------------

// File: rtl/ysyx_pkg.sv
// Shared constants for the RV32E register file and its pending-write scoreboard.
package ysyx_pkg;
  localparam int                    REG_IDX_W  = 4;
  localparam int                    NR_REG_DEF = 16;
  localparam logic [REG_IDX_W-1:0]  X0_IDX     = '0;
endpackage

// File: rtl/ysyx_sb_cnt.sv
// One scoreboard slot: saturating up/down counter of in-flight writes to a register,
// with a synchronous clear used by pipeline flush.
module ysyx_sb_cnt #(
  parameter int CNT_W = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic inc_i,
  input  logic dec_i,
  input  logic clr_i,
  output logic busy_o,
  output logic full_o
);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             inc_eff, dec_eff;

  assign busy_o  = (cnt_q != '0);
  assign full_o  = (cnt_q == '1);
  // A writeback with nothing in flight must not underflow; a full counter only
  // accepts an issue when a writeback frees a slot in the same cycle.
  assign dec_eff = dec_i & busy_o;
  assign inc_eff = inc_i & (~full_o | dec_eff);

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)                   cnt_d = '0;
    else if (inc_eff && !dec_eff) cnt_d = cnt_q + CNT_W'(1);
    else if (dec_eff && !inc_eff) cnt_d = cnt_q - CNT_W'(1);
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
endmodule

// File: rtl/ysyx_rf_sb.sv
// Register file with writeback bypass plus per-register pending-write scoreboard
// feeding decode's hazard check (rf_table) and issue back-pressure (issue_ready).
module ysyx_rf_sb
  import ysyx_pkg::*;
#(
  parameter int BIT_W  = 32,
  parameter int NR_REG = NR_REG_DEF,
  parameter int CNT_W  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [REG_IDX_W-1:0] rs1,
  input  logic [REG_IDX_W-1:0] rs2,
  output logic [BIT_W-1:0]     rdata1,
  output logic [BIT_W-1:0]     rdata2,
  input  logic                 issue_valid,
  input  logic                 issue_wen,
  input  logic [REG_IDX_W-1:0] issue_rd,
  output logic                 issue_ready,
  input  logic                 wb_valid,
  input  logic                 wb_wen,
  input  logic [REG_IDX_W-1:0] wb_rd,
  input  logic [BIT_W-1:0]     wb_data,
  input  logic                 flush,
  output logic [NR_REG-1:0]    rf_table
);
  logic [BIT_W-1:0]  regs_q [NR_REG];
  logic [NR_REG-1:0] busy_vec, full_vec, inc_vec, dec_vec;
  logic              wb_we;

  assign wb_we = wb_valid & wb_wen;

  // NOTE: the data array is reset because a reset must discard all architectural state at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NR_REG; i++) regs_q[i] <= '0;
    end else if (wb_we && wb_rd != X0_IDX) begin
      regs_q[wb_rd] <= wb_data;
    end
  end

  always_comb begin
    rdata1 = '0;
    rdata2 = '0;
    if (rs1 != X0_IDX) rdata1 = (wb_we && wb_rd == rs1) ? wb_data : regs_q[rs1];
    if (rs2 != X0_IDX) rdata2 = (wb_we && wb_rd == rs2) ? wb_data : regs_q[rs2];
  end

  // x0 never has a counter; its slot is tied idle.
  assign busy_vec[0] = 1'b0;
  assign full_vec[0] = 1'b0;
  assign inc_vec[0]  = 1'b0;
  assign dec_vec[0]  = 1'b0;

  for (genvar i = 1; i < NR_REG; i++) begin : g_cnt
    assign inc_vec[i] = issue_valid & issue_wen & issue_ready & (issue_rd == REG_IDX_W'(i));
    assign dec_vec[i] = wb_we & (wb_rd == REG_IDX_W'(i)) & busy_vec[i];

    ysyx_sb_cnt #(.CNT_W(CNT_W)) u_cnt (
      .clk    (clk),
      .rst    (rst),
      .inc_i  (inc_vec[i]),
      .dec_i  (dec_vec[i]),
      .clr_i  (flush),
      .busy_o (busy_vec[i]),
      .full_o (full_vec[i])
    );
  end

  assign rf_table    = busy_vec;
  assign issue_ready = !(issue_wen && issue_rd != X0_IDX && full_vec[issue_rd] && !dec_vec[issue_rd]);
endmodule

// File: tb/tb_ysyx_rf_sb.sv
// Directed bench for ysyx_rf_sb: expectations are queued as stimulus is applied
// and popped in order when the corresponding DUT output is sampled.
module tb_ysyx_rf_sb;
  logic        clk, rst;
  logic [3:0]  rs1, rs2, issue_rd, wb_rd;
  logic [31:0] rdata1, rdata2, wb_data;
  logic        issue_valid, issue_wen, issue_ready, wb_valid, wb_wen, flush;
  logic [15:0] rf_table;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];

  ysyx_rf_sb dut (
    .clk(clk), .rst(rst), .rs1(rs1), .rs2(rs2), .rdata1(rdata1), .rdata2(rdata2),
    .issue_valid(issue_valid), .issue_wen(issue_wen), .issue_rd(issue_rd),
    .issue_ready(issue_ready), .wb_valid(wb_valid), .wb_wen(wb_wen), .wb_rd(wb_rd),
    .wb_data(wb_data), .flush(flush), .rf_table(rf_table)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic expect_v(input logic [31:0] v);
    exp_q.push_back(v);
  endtask

  task automatic check(input string tag, input logic [31:0] obs);
    logic [31:0] e;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL %s: got %h expected <empty scoreboard>", tag, obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e) else begin
        bad++;
        $error("FAIL %s: got %h expected %h", tag, obs, e);
      end
    end
  endtask

  task automatic clear_in();
    issue_valid = 0; issue_wen = 0; issue_rd = 0;
    wb_valid = 0; wb_wen = 0; wb_rd = 0; wb_data = 0; flush = 0;
  endtask

  task automatic issue(input logic [3:0] rd);
    issue_valid = 1; issue_wen = 1; issue_rd = rd;
  endtask

  task automatic wb(input logic [3:0] rd, input logic [31:0] d);
    wb_valid = 1; wb_wen = 1; wb_rd = rd; wb_data = d;
  endtask

  // Advance past the next rising edge, leaving time to drive before sampling.
  task automatic step();
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1; rs1 = 0; rs2 = 0; clear_in();
    #2;
    expect_v(32'h0); check("rst_table", {16'h0, rf_table});
    expect_v(32'h1); check("rst_ready", {31'h0, issue_ready});
    #1 rst = 0;
    step();

    // write x5 and issue x3, then reset asynchronously mid-cycle
    wb(5, 32'h1234); issue(3); rs1 = 5; #1;
    expect_v(32'h1234); check("x5_bypass", rdata1);
    step(); clear_in(); #1;
    expect_v(32'h1234); check("x5_array", rdata1);
    expect_v(32'h8);    check("pre_rst_table", {16'h0, rf_table});
    rst = 1; #1;
    expect_v(32'h0); check("async_rst_rdata", rdata1);
    expect_v(32'h0); check("async_rst_table", {16'h0, rf_table});
    expect_v(32'h1); check("async_rst_ready", {31'h0, issue_ready});
    #1 rst = 0;

    // issue / writeback with bypass
    step(); issue(3);
    step(); clear_in(); #1;
    expect_v(32'h8); check("iss3_table", {16'h0, rf_table});
    wb(3, 32'hDEADBEEF); rs1 = 3; #1;
    expect_v(32'hDEADBEEF); check("wb3_bypass", rdata1);
    expect_v(32'h8);        check("wb3_no_lookahead", {16'h0, rf_table});
    step(); clear_in(); #1;
    expect_v(32'h0);        check("wb3_table", {16'h0, rf_table});
    expect_v(32'hDEADBEEF); check("wb3_array", rdata1);

    // WAW on x7
    issue(7); step(); step(); clear_in(); #1;
    expect_v(32'h80); check("waw_two", {16'h0, rf_table});
    wb(7, 32'h7); step(); clear_in(); #1;
    expect_v(32'h80); check("waw_one_left", {16'h0, rf_table});
    wb(7, 32'h77); step(); clear_in(); #1;
    expect_v(32'h0); check("waw_done", {16'h0, rf_table});

    // saturation on x2
    issue(2); step(); step(); step(); #1;
    expect_v(32'h0); check("sat_ready_low", {31'h0, issue_ready});
    expect_v(32'h4); check("sat_table", {16'h0, rf_table});
    wb(2, 32'h22); #1;
    expect_v(32'h1); check("sat_wb_frees", {31'h0, issue_ready});
    step(); wb_valid = 0; wb_wen = 0; #1;
    expect_v(32'h0); check("sat_still_full", {31'h0, issue_ready});
    clear_in(); wb(2, 32'h22); step(); step(); clear_in(); #1;
    expect_v(32'h4); check("sat_cnt_was_3", {16'h0, rf_table});
    wb(2, 32'h22); step(); clear_in(); #1;
    expect_v(32'h0); check("sat_drained", {16'h0, rf_table});

    // x0 issue and writeback are ignored
    issue(0); wb(0, 32'h55); rs1 = 0; #1;
    expect_v(32'h0); check("x0_bypass", rdata1);
    expect_v(32'h1); check("x0_ready", {31'h0, issue_ready});
    step(); clear_in(); #1;
    expect_v(32'h0); check("x0_table", {16'h0, rf_table});
    expect_v(32'h0); check("x0_read", rdata1);

    // same-cycle issue and writeback on x4 with cnt=1
    issue(4); step(); wb(4, 32'h44); step(); clear_in(); #1;
    expect_v(32'h10); check("x4_cnt_kept", {16'h0, rf_table});
    wb(4, 32'h45); step(); clear_in(); #1;
    expect_v(32'h0); check("x4_cnt_one", {16'h0, rf_table});

    // flush with pending x1 and x9, same-cycle wb x9 and ignored issue x5
    issue(1); step(); issue(9); step(); clear_in(); #1;
    expect_v(32'h202); check("fl_pending", {16'h0, rf_table});
    flush = 1; wb(9, 32'hA5); issue(5); rs2 = 9; #1;
    expect_v(32'hA5); check("fl_bypass2", rdata2);
    step(); clear_in(); #1;
    expect_v(32'h0);  check("fl_table", {16'h0, rf_table});
    expect_v(32'hA5); check("fl_reg9", rdata2);
    wb(1, 32'h77); rs1 = 1; step(); clear_in(); #1;
    expect_v(32'h0);  check("fl_no_underflow", {16'h0, rf_table});
    expect_v(32'h77); check("fl_reg1", rdata1);
    issue(1); step(); clear_in(); #1;
    expect_v(32'h2); check("fl_reissue", {16'h0, rf_table});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
